// File: rtl/apb_arb_pkg.sv
// Shared types for the two-port APB requester arbiter.
// Holds the FSM state encoding, the timeout counter width and the round-robin pick helper.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT_WIDTH = 16;

  // Returns 1 when port B should win.
  // On a tie, the port that did not own the bus last wins.
  function automatic logic rr_pick_b(input logic req_a, input logic req_b, input logic last_b);
    if (req_a && req_b) begin
      return !last_b;
    end
    return req_b;
  endfunction

endpackage

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter sharing one APB requester port between two upstream requesters.
// Optional ACCESS-phase abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_requester_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // upstream port A
  input  logic                    up_a_psel,
  input  logic                    up_a_penable,
  input  logic                    up_a_pwrite,
  input  logic [ADDR_WIDTH-1:0]   up_a_paddr,
  input  logic [DATA_WIDTH-1:0]   up_a_pwdata,
  input  logic [DATA_WIDTH/8-1:0] up_a_pstrb,
  input  logic [2:0]              up_a_pprot,
  output logic [DATA_WIDTH-1:0]   up_a_prdata,
  output logic                    up_a_pready,
  output logic                    up_a_pslverr,
  // upstream port B
  input  logic                    up_b_psel,
  input  logic                    up_b_penable,
  input  logic                    up_b_pwrite,
  input  logic [ADDR_WIDTH-1:0]   up_b_paddr,
  input  logic [DATA_WIDTH-1:0]   up_b_pwdata,
  input  logic [DATA_WIDTH/8-1:0] up_b_pstrb,
  input  logic [2:0]              up_b_pprot,
  output logic [DATA_WIDTH-1:0]   up_b_prdata,
  output logic                    up_b_pready,
  output logic                    up_b_pslverr,
  // downstream requester
  output logic                    down_psel,
  output logic                    down_penable,
  output logic                    down_pwrite,
  output logic [ADDR_WIDTH-1:0]   down_paddr,
  output logic [DATA_WIDTH-1:0]   down_pwdata,
  output logic [DATA_WIDTH/8-1:0] down_pstrb,
  output logic [2:0]              down_pprot,
  input  logic [DATA_WIDTH-1:0]   down_prdata,
  input  logic                    down_pready,
  input  logic                    down_pslverr,
  output logic                    grant_b
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  arb_state_t              state_q;
  logic                    grant_b_q;
  logic                    psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [StrbWidth-1:0]    pstrb_q;
  logic [2:0]              pprot_q;
  logic                    a_pready_q, b_pready_q;
  logic                    a_pslverr_q, b_pslverr_q;
  logic [DATA_WIDTH-1:0]   a_prdata_q, b_prdata_q;

  logic                    any_req;
  logic                    pick_b;
  logic                    access_end;
  logic [DATA_WIDTH-1:0]   rsp_prdata;
  logic                    rsp_pslverr;

  // penable is deliberately ignored: a request is psel alone.
  logic unused_inputs;
  assign unused_inputs = ^{up_a_penable, up_b_penable};

  assign any_req = up_a_psel | up_b_psel;
  assign pick_b  = rr_pick_b(up_a_psel, up_b_psel, grant_b_q);

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [ARB_TIMEOUT_WIDTH-1:0] TimeoutLast = ARB_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [ARB_TIMEOUT_WIDTH-1:0] to_cnt_q;
  logic                         timed_out;

  assign timed_out = (state_q == ARB_ACCESS) && !down_pready && (to_cnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == ARB_ACCESS) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  logic timed_out;
  assign timed_out = 1'b0;
`endif

  // Response selection: a timeout abort reports an error with zero data.
  always_comb begin
    access_end  = 1'b0;
    rsp_prdata  = down_prdata;
    rsp_pslverr = down_pslverr;
    if (state_q == ARB_ACCESS) begin
      if (down_pready) begin
        access_end = 1'b1;
      end else if (timed_out) begin
        access_end  = 1'b1;
        rsp_prdata  = '0;
        rsp_pslverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_b_q   <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      a_pready_q  <= 1'b0;
      b_pready_q  <= 1'b0;
      a_pslverr_q <= 1'b0;
      b_pslverr_q <= 1'b0;
      a_prdata_q  <= '0;
      b_prdata_q  <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_b_q <= pick_b;
            pwrite_q  <= pick_b ? up_b_pwrite : up_a_pwrite;
            paddr_q   <= pick_b ? up_b_paddr  : up_a_paddr;
            pwdata_q  <= pick_b ? up_b_pwdata : up_a_pwdata;
            pstrb_q   <= pick_b ? up_b_pstrb  : up_a_pstrb;
            pprot_q   <= pick_b ? up_b_pprot  : up_a_pprot;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (access_end) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (grant_b_q) begin
              b_pready_q  <= 1'b1;
              b_prdata_q  <= rsp_prdata;
              b_pslverr_q <= rsp_pslverr;
            end else begin
              a_pready_q  <= 1'b1;
              a_prdata_q  <= rsp_prdata;
              a_pslverr_q <= rsp_pslverr;
            end
            state_q <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          // Completion is a single-cycle pulse; response data returns to 0 with it.
          a_pready_q  <= 1'b0;
          b_pready_q  <= 1'b0;
          a_prdata_q  <= '0;
          b_prdata_q  <= '0;
          a_pslverr_q <= 1'b0;
          b_pslverr_q <= 1'b0;
          state_q     <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign down_psel    = psel_q;
  assign down_penable = penable_q;
  assign down_pwrite  = pwrite_q;
  assign down_paddr   = paddr_q;
  assign down_pwdata  = pwdata_q;
  assign down_pstrb   = pstrb_q;
  assign down_pprot   = pprot_q;

  assign up_a_pready  = a_pready_q;
  assign up_a_prdata  = a_prdata_q;
  assign up_a_pslverr = a_pslverr_q;
  assign up_b_pready  = b_pready_q;
  assign up_b_prdata  = b_prdata_q;
  assign up_b_pslverr = b_pslverr_q;

  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter: a vector table of single transfers,
// then hand sequences for ties, back-to-back ordering, reset mid-transfer and timeout.
module tb_apb_requester_arbiter;

  logic        clk;
  logic        rst;

  logic        u_psel    [2];
  logic        u_penable [2];
  logic        u_pwrite  [2];
  logic [31:0] u_paddr   [2];
  logic [31:0] u_pwdata  [2];
  logic [3:0]  u_pstrb   [2];
  logic [2:0]  u_pprot   [2];
  logic [31:0] u_prdata  [2];
  logic        u_pready  [2];
  logic        u_pslverr [2];

  logic        down_psel, down_penable, down_pwrite;
  logic [31:0] down_paddr, down_pwdata, down_prdata;
  logic [3:0]  down_pstrb;
  logic [2:0]  down_pprot;
  logic        down_pready, down_pslverr;
  logic        grant_b;

  // completer configuration
  int          cfg_wait;
  logic        cfg_never;
  logic [31:0] cfg_rdata;
  logic        cfg_slverr;
  int          acc_cnt;

  // downstream monitor
  logic [31:0] mon_addr, mon_wdata;
  logic        mon_write;
  logic [3:0]  mon_strb;
  logic [2:0]  mon_prot;
  logic        log_port [$];

  int n_cmp;
  int n_err;

  apb_requester_arbiter #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_a_psel   (u_psel[0]),
    .up_a_penable(u_penable[0]),
    .up_a_pwrite (u_pwrite[0]),
    .up_a_paddr  (u_paddr[0]),
    .up_a_pwdata (u_pwdata[0]),
    .up_a_pstrb  (u_pstrb[0]),
    .up_a_pprot  (u_pprot[0]),
    .up_a_prdata (u_prdata[0]),
    .up_a_pready (u_pready[0]),
    .up_a_pslverr(u_pslverr[0]),
    .up_b_psel   (u_psel[1]),
    .up_b_penable(u_penable[1]),
    .up_b_pwrite (u_pwrite[1]),
    .up_b_paddr  (u_paddr[1]),
    .up_b_pwdata (u_pwdata[1]),
    .up_b_pstrb  (u_pstrb[1]),
    .up_b_pprot  (u_pprot[1]),
    .up_b_prdata (u_prdata[1]),
    .up_b_pready (u_pready[1]),
    .up_b_pslverr(u_pslverr[1]),
    .down_psel   (down_psel),
    .down_penable(down_penable),
    .down_pwrite (down_pwrite),
    .down_paddr  (down_paddr),
    .down_pwdata (down_pwdata),
    .down_pstrb  (down_pstrb),
    .down_pprot  (down_pprot),
    .down_prdata (down_prdata),
    .down_pready (down_pready),
    .down_pslverr(down_pslverr),
    .grant_b     (grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer: ready after cfg_wait ACCESS cycles, driven on the falling edge.
  initial begin
    down_pready  = 1'b0;
    down_prdata  = '0;
    down_pslverr = 1'b0;
    acc_cnt      = 0;
    forever begin
      @(negedge clk);
      if (down_psel && down_penable) begin
        down_pready  = (acc_cnt == cfg_wait) && !cfg_never;
        down_prdata  = cfg_rdata;
        down_pslverr = cfg_slverr;
        acc_cnt++;
      end else begin
        down_pready  = 1'b0;
        down_pslverr = 1'b0;
        acc_cnt      = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst && down_psel && down_penable && down_pready) begin
        mon_addr  = down_paddr;
        mon_wdata = down_pwdata;
        mon_write = down_pwrite;
        mon_strb  = down_pstrb;
        mon_prot  = down_pprot;
        log_port.push_back(grant_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One upstream transfer; lat counts rising edges from the sampling edge to visible pready.
  task automatic do_xfer(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    u_psel[p]    = 1'b1;
    u_penable[p] = 1'b0;
    u_pwrite[p]  = wr;
    u_paddr[p]   = addr;
    u_pwdata[p]  = wdata;
    u_pstrb[p]   = strb;
    u_pprot[p]   = 3'(p + 1);
    lat          = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (u_pready[p]) break;
      if (lat >= 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL xfer_timeout port %0d: no pready after %0d cycles, expected pready", p,
                 lat);
        break;
      end
      u_penable[p] = 1'b1;
    end
    rdata = u_prdata[p];
    err   = u_pslverr[p];
    @(negedge clk);
    u_psel[p]    = 1'b0;
    u_penable[p] = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat, lat_a, lat_b;
    logic [31:0] rd, rd_a, rd_b;
    logic        er, er_a, er_b;
    logic        seen;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{0, 1'b1, 32'hc000_0404, 32'h0000_0055, 4'hf, 0, 32'h0, 1'b0, 3};
    vecs[1] = '{1, 1'b0, 32'hc000_0000, 32'h0,         4'h0, 5, 32'h0021_0a79, 1'b0, 8};
    vecs[2] = '{0, 1'b0, 32'hc000_1008, 32'h0,         4'h0, 1, 32'hdead_beef, 1'b1, 4};
    vecs[3] = '{1, 1'b1, 32'hc000_2010, 32'ha5a5_5a5a, 4'h3, 2, 32'h0,         1'b0, 5};
    vecs[4] = '{0, 1'b0, 32'hc000_0ffc, 32'h0,         4'h0, 0, 32'hffff_ffff, 1'b0, 3};
    vecs[5] = '{1, 1'b0, 32'hc000_3000, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b1, 3};

    cfg_wait   = 0;
    cfg_never  = 1'b0;
    cfg_rdata  = '0;
    cfg_slverr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      u_psel[p]    = 1'b0;
      u_penable[p] = 1'b0;
      u_pwrite[p]  = 1'b0;
      u_paddr[p]   = '0;
      u_pwdata[p]  = '0;
      u_pstrb[p]   = '0;
      u_pprot[p]   = '0;
    end

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_down_psel", 32'(down_psel), 32'd0);
    chk("rst_down_penable", 32'(down_penable), 32'd0);
    chk("rst_down_pwrite", 32'(down_pwrite), 32'd0);
    chk("rst_down_paddr", down_paddr, 32'd0);
    chk("rst_down_pwdata", down_pwdata, 32'd0);
    chk("rst_down_pstrb", 32'(down_pstrb), 32'd0);
    chk("rst_a_pready", 32'(u_pready[0]), 32'd0);
    chk("rst_b_pready", 32'(u_pready[1]), 32'd0);
    chk("rst_grant_b", 32'(grant_b), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // tie straight after reset: A first, B one IDLE cycle later
    log_port.delete();
    cfg_rdata = 32'h0000_00a1;
    fork
      begin
        do_xfer(0, 1'b0, 32'hc000_0100, 32'h0, 4'h0, lat_a, rd_a, er_a);
        chk("tie_a_grant_b", 32'(grant_b), 32'd0);
        chk("tie_b_pready_while_a", 32'(u_pready[1]), 32'd0);
        chk("tie_b_prdata_while_a", u_prdata[1], 32'd0);
      end
      begin
        do_xfer(1, 1'b0, 32'hc000_0200, 32'h0, 4'h0, lat_b, rd_b, er_b);
        chk("tie_b_grant_b", 32'(grant_b), 32'd1);
        chk("tie_a_pready_while_b", 32'(u_pready[0]), 32'd0);
      end
    join
    chk("tie_a_latency", 32'(lat_a), 32'd3);
    chk("tie_b_latency", 32'(lat_b), 32'd7);
    chk("tie_log_size", 32'(log_port.size()), 32'd2);
    if (log_port.size() == 2) begin
      chk("tie_order0", 32'(log_port[0]), 32'd0);
      chk("tie_order1", 32'(log_port[1]), 32'd1);
    end

    // table of isolated transfers
    for (int i = 0; i < 6; i++) begin
      cfg_wait   = vecs[i].waits;
      cfg_rdata  = vecs[i].rdata;
      cfg_slverr = vecs[i].slverr;
      repeat (2) @(posedge clk);
      do_xfer(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, lat, rd, er);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_prdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_pslverr", i), 32'(er), 32'(vecs[i].slverr));
      chk($sformatf("v%0d_down_paddr", i), mon_addr, vecs[i].addr);
      chk($sformatf("v%0d_down_pwrite", i), 32'(mon_write), 32'(vecs[i].wr));
      chk($sformatf("v%0d_down_pstrb", i), 32'(mon_strb), 32'(vecs[i].strb));
      chk($sformatf("v%0d_down_pprot", i), 32'(mon_prot), 32'(vecs[i].port + 1));
      if (vecs[i].wr) chk($sformatf("v%0d_down_pwdata", i), mon_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_grant_b", i), 32'(grant_b), 32'(vecs[i].port));
    end

    // A issues 3 back-to-back while B keeps requesting: strict alternation
    cfg_wait   = 0;
    cfg_slverr = 1'b0;
    repeat (2) @(posedge clk);
    log_port.delete();
    fork
      begin
        repeat (3) do_xfer(0, 1'b1, 32'hc000_0400, 32'h11, 4'hf, lat_a, rd_a, er_a);
      end
      begin
        repeat (2) do_xfer(1, 1'b1, 32'hc000_0500, 32'h22, 4'hf, lat_b, rd_b, er_b);
      end
    join
    chk("b2b_log_size", 32'(log_port.size()), 32'd5);
    if (log_port.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("b2b_order%0d", i), 32'(log_port[i]), 32'(i % 2));
      end
    end

    // reset pulsed during ACCESS
    cfg_wait = 5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    u_psel[0]  = 1'b1;
    u_pwrite[0] = 1'b1;
    u_paddr[0] = 32'hc000_0800;
    u_pwdata[0] = 32'h99;
    u_pstrb[0] = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_in_access", 32'({down_psel, down_penable}), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_down_psel", 32'(down_psel), 32'd0);
    chk("midrst_down_penable", 32'(down_penable), 32'd0);
    chk("midrst_down_paddr", down_paddr, 32'd0);
    chk("midrst_down_pwdata", down_pwdata, 32'd0);
    chk("midrst_down_pstrb", 32'(down_pstrb), 32'd0);
    chk("midrst_grant_b", 32'(grant_b), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    u_psel[0] = 1'b0;
    seen      = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (u_pready[0] || u_pready[1]) seen = 1'b1;
    end
    chk("midrst_no_completion", 32'(seen), 32'd0);
    cfg_wait  = 0;
    cfg_rdata = 32'h0000_0777;
    do_xfer(0, 1'b0, 32'hc000_0900, 32'h0, 4'h0, lat, rd, er);
    chk("postrst_latency", 32'(lat), 32'd3);
    chk("postrst_prdata", rd, 32'h0000_0777);

`ifdef APB_ARB_TIMEOUT_EN
    // completer never ready: abort after 16 ACCESS cycles with an error and zero data
    cfg_never = 1'b1;
    cfg_rdata = 32'hbad0_bad0;
    repeat (2) @(posedge clk);
    do_xfer(1, 1'b0, 32'hc000_0a00, 32'h0, 4'h0, lat, rd, er);
    chk("timeout_latency", 32'(lat), 32'd18);
    chk("timeout_pslverr", 32'(er), 32'd1);
    chk("timeout_prdata", rd, 32'd0);
    cfg_never = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
